// File: rtl/battle_pkg.sv
// rtl/battle_pkg.sv - shared grid constants, cell type and rocket state for the battle display
package battle_pkg;

    localparam int CELL_SHIFT   = 5;
    localparam int GRID_ROWS    = 15;
    localparam int GRID_COLS    = 20;
    localparam int X_FRAME_SIZE = 543;
    localparam int Y_FRAME_SIZE = 479;
    localparam logic [1:0] KEY_LEFT = 2'd1;
    localparam int LEFT_CORR    = 5;

    typedef struct packed {
        logic [3:0] row;
        logic [4:0] col;
    } cell_t;

    typedef enum logic {
        SPENT = 1'b0,
        ARMED = 1'b1
    } rocket_state_t;

    // A left-heading rocket's leading edge sits a few pixels past the brick it hit.
    function automatic cell_t pixel_to_cell(input logic [10:0] px,
                                            input logic [10:0] py,
                                            input logic [1:0]  key);
        cell_t      c;
        logic [10:0] x;
        if (key == KEY_LEFT)
            x = (px < 11'(LEFT_CORR)) ? 11'd0 : px - 11'(LEFT_CORR);
        else
            x = px;
        c.col = 5'(x >> CELL_SHIFT);
        c.row = 4'(py >> CELL_SHIFT);
        return c;
    endfunction

endpackage

// File: rtl/hit_fifo.sv
// rtl/hit_fifo.sv - small cell FIFO; push and pop in one cycle both take effect even when full
module hit_fifo
    import battle_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic  clk,
    input  logic  reset,
    input  logic  push,
    input  cell_t push_data,
    input  logic  pop,
    output cell_t head,
    output logic  full,
    output logic  empty
);

    localparam int AW = $clog2(DEPTH);

    cell_t         mem_q [DEPTH];
    cell_t         mem_d [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0]   count_q, count_d;
    logic          do_push, do_pop;

    assign full  = (count_q == (AW+1)'(DEPTH));
    assign empty = (count_q == '0);
    assign head  = mem_q[rd_ptr_q];

    always_comb begin
        do_pop   = pop & ~empty;
        do_push  = push & (~full | do_pop);
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        // When full, wr_ptr equals rd_ptr: the head is read out this cycle before being replaced.
        if (do_push) begin
            mem_d[wr_ptr_q] = push_data;
            wr_ptr_d        = wr_ptr_q + 1'b1;
        end
        if (do_pop)
            rd_ptr_d = rd_ptr_q + 1'b1;
        if (do_push && !do_pop)
            count_d = count_q + 1'b1;
        else if (!do_push && do_pop)
            count_d = count_q - 1'b1;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++)
                mem_q[i] <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule

// File: rtl/brick_hit_manager.sv
// rtl/brick_hit_manager.sv - detects rocket/brick overlaps, one hit per rocket per frame, queues cell clears
module brick_hit_manager
    import battle_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic [10:0] pixelX,
    input  logic [10:0] pixelY,
    input  logic        start_of_frame,
    input  logic        brick_draw,
    input  logic        rocket1_draw,
    input  logic        rocket2_draw,
    input  logic [1:0]  lastkey1,
    input  logic [1:0]  lastkey2,
    output logic        clr_valid,
    input  logic        clr_ready,
    output logic [3:0]  clr_row,
    output logic [4:0]  clr_col,
    output logic        rocket1_hit,
    output logic        rocket2_hit,
    output logic        overflow
);

    logic          in_frame;
    logic          ovl1_q, ovl1_d, ovl2_q, ovl2_d;
    cell_t         cell1_q, cell1_d, cell2_q, cell2_d;
    rocket_state_t st1_q, st1_d, st2_q, st2_d;
    logic          hit1_q, hit1_d, hit2_q, hit2_d;
    logic          pend_valid_q, pend_valid_d;
    cell_t         pend_cell_q, pend_cell_d;
    logic          overflow_q, overflow_d;
    logic          ev1, ev2, ev2_new;
    logic          fifo_push, fifo_full, fifo_empty, fifo_pop, can_push;
    cell_t         fifo_data, fifo_head;

    assign in_frame = (pixelX < 11'(X_FRAME_SIZE)) & (pixelY < 11'(Y_FRAME_SIZE));

    assign clr_valid   = ~fifo_empty;
    assign clr_row     = fifo_head.row;
    assign clr_col     = fifo_head.col;
    assign rocket1_hit = hit1_q;
    assign rocket2_hit = hit2_q;
    assign overflow    = overflow_q;
    assign fifo_pop    = clr_valid & clr_ready;
    assign can_push    = ~fifo_full | fifo_pop;

    always_comb begin
        ovl1_d  = rocket1_draw & brick_draw & in_frame;
        ovl2_d  = rocket2_draw & brick_draw & in_frame;
        cell1_d = pixel_to_cell(pixelX, pixelY, lastkey1);
        cell2_d = pixel_to_cell(pixelX, pixelY, lastkey2);

        // A frame start arms the rocket in the same cycle it may consume an overlap.
        ev1 = ovl1_q & ((st1_q == ARMED) | start_of_frame);
        ev2 = ovl2_q & ((st2_q == ARMED) | start_of_frame);
        st1_d = ev1 ? SPENT : (start_of_frame ? ARMED : st1_q);
        st2_d = ev2 ? SPENT : (start_of_frame ? ARMED : st2_q);
        hit1_d = ev1;
        hit2_d = ev2;
        ev2_new = ev2 & ~(ev1 & (cell1_q == cell2_q));
    end

    always_comb begin
        fifo_push    = 1'b0;
        fifo_data    = cell1_q;
        pend_valid_d = pend_valid_q;
        pend_cell_d  = pend_cell_q;
        overflow_d   = overflow_q;
        if (pend_valid_q) begin
            // The pending entry holds the single push slot; new events may only refill it.
            if (can_push) begin
                fifo_push    = 1'b1;
                fifo_data    = pend_cell_q;
                pend_valid_d = 1'b0;
            end
            if (ev1) begin
                if (!pend_valid_d) begin
                    pend_valid_d = 1'b1;
                    pend_cell_d  = cell1_q;
                end else begin
                    overflow_d = 1'b1;
                end
            end
            if (ev2_new) begin
                if (!pend_valid_d) begin
                    pend_valid_d = 1'b1;
                    pend_cell_d  = cell2_q;
                end else begin
                    overflow_d = 1'b1;
                end
            end
        end else begin
            if (ev1) begin
                fifo_push = 1'b1;
                fifo_data = cell1_q;
                if (!can_push)
                    overflow_d = 1'b1;
            end
            if (ev2_new) begin
                if (!ev1) begin
                    fifo_push = 1'b1;
                    fifo_data = cell2_q;
                    if (!can_push)
                        overflow_d = 1'b1;
                end else begin
                    pend_valid_d = 1'b1;
                    pend_cell_d  = cell2_q;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ovl1_q       <= 1'b0;
            ovl2_q       <= 1'b0;
            cell1_q      <= '0;
            cell2_q      <= '0;
            st1_q        <= SPENT;
            st2_q        <= SPENT;
            hit1_q       <= 1'b0;
            hit2_q       <= 1'b0;
            pend_valid_q <= 1'b0;
            pend_cell_q  <= '0;
            overflow_q   <= 1'b0;
        end else begin
            ovl1_q       <= ovl1_d;
            ovl2_q       <= ovl2_d;
            cell1_q      <= cell1_d;
            cell2_q      <= cell2_d;
            st1_q        <= st1_d;
            st2_q        <= st2_d;
            hit1_q       <= hit1_d;
            hit2_q       <= hit2_d;
            pend_valid_q <= pend_valid_d;
            pend_cell_q  <= pend_cell_d;
            overflow_q   <= overflow_d;
        end
    end

    hit_fifo #(.DEPTH(4)) u_hit_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (fifo_push),
        .push_data (fifo_data),
        .pop       (fifo_pop),
        .head      (fifo_head),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

endmodule

// File: tb/tb_brick_hit_manager.sv
// tb/tb_brick_hit_manager.sv - directed self-checking bench for brick_hit_manager
module tb_brick_hit_manager;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [10:0] pixelX = '0;
    logic [10:0] pixelY = '0;
    logic        start_of_frame = 1'b0;
    logic        brick_draw = 1'b0;
    logic        rocket1_draw = 1'b0;
    logic        rocket2_draw = 1'b0;
    logic [1:0]  lastkey1 = '0;
    logic [1:0]  lastkey2 = '0;
    logic        clr_valid;
    logic        clr_ready = 1'b0;
    logic [3:0]  clr_row;
    logic [4:0]  clr_col;
    logic        rocket1_hit;
    logic        rocket2_hit;
    logic        overflow;

    int n_checks = 0;
    int n_errors = 0;
    int hits1 = 0;
    int hits2 = 0;
    int base1, base2;

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (rocket1_hit) hits1++;
        if (rocket2_hit) hits2++;
    end

    brick_hit_manager dut (
        .clk            (clk),
        .reset          (reset),
        .pixelX         (pixelX),
        .pixelY         (pixelY),
        .start_of_frame (start_of_frame),
        .brick_draw     (brick_draw),
        .rocket1_draw   (rocket1_draw),
        .rocket2_draw   (rocket2_draw),
        .lastkey1       (lastkey1),
        .lastkey2       (lastkey2),
        .clr_valid      (clr_valid),
        .clr_ready      (clr_ready),
        .clr_row        (clr_row),
        .clr_col        (clr_col),
        .rocket1_hit    (rocket1_hit),
        .rocket2_hit    (rocket2_hit),
        .overflow       (overflow)
    );

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic sof();
        start_of_frame = 1'b1;
        tick();
        start_of_frame = 1'b0;
    endtask

    // One-cycle overlap; returns in the cycle where the hit pulse and new entry are visible.
    task automatic hit_at(input logic r1, input logic r2, input int x, input int y,
                          input logic [1:0] k1, input logic [1:0] k2);
        pixelX = 11'(x);
        pixelY = 11'(y);
        lastkey1 = k1;
        lastkey2 = k2;
        rocket1_draw = r1;
        rocket2_draw = r2;
        brick_draw = 1'b1;
        tick();
        rocket1_draw = 1'b0;
        rocket2_draw = 1'b0;
        brick_draw = 1'b0;
        tick();
    endtask

    task automatic pop_one();
        clr_ready = 1'b1;
        tick();
        clr_ready = 1'b0;
    endtask

    initial begin
        tick();
        tick();
        reset = 1'b0;
        tick();
        check("rst_valid", clr_valid, 0);
        check("rst_hit1", rocket1_hit, 0);
        check("rst_hit2", rocket2_hit, 0);
        check("rst_ovf", overflow, 0);
        check("rst_row", clr_row, 0);
        check("rst_col", clr_col, 0);

        // No start_of_frame yet: overlaps are ignored
        hit_at(1, 1, 100, 70, 0, 0);
        tick();
        check("pre_sof_hits", hits1 + hits2, 0);
        check("pre_sof_valid", clr_valid, 0);

        // Single hit at (100,70)
        sof();
        hit_at(1, 0, 100, 70, 0, 0);
        check("single_hit1", rocket1_hit, 1);
        check("single_valid", clr_valid, 1);
        check("single_row", clr_row, 2);
        check("single_col", clr_col, 3);
        tick();
        check("single_hit1_end", rocket1_hit, 0);
        check("single_hits", hits1, 1);
        pop_one();
        check("single_popped", clr_valid, 0);

        // Left correction
        hit_at(0, 1, 130, 40, 0, 1);
        check("left_hit2", rocket2_hit, 1);
        check("left_row", clr_row, 1);
        check("left_col", clr_col, 3);
        pop_one();
        sof();
        hit_at(0, 1, 3, 200, 0, 1);
        check("left_sat_valid", clr_valid, 1);
        check("left_sat_row", clr_row, 6);
        check("left_sat_col", clr_col, 0);
        pop_one();
        check("left_sat_popped", clr_valid, 0);

        // One event per frame
        sof();
        base1 = hits1;
        rocket1_draw = 1'b1;
        brick_draw = 1'b1;
        lastkey1 = 2'd0;
        pixelX = 11'd40;  pixelY = 11'd40;  tick();
        pixelX = 11'd64;  pixelY = 11'd64;  tick();
        pixelX = 11'd100; pixelY = 11'd100; tick();
        rocket1_draw = 1'b0;
        brick_draw = 1'b0;
        tick();
        tick();
        check("opf_hits", hits1 - base1, 1);
        check("opf_row", clr_row, 1);
        check("opf_col", clr_col, 1);
        pop_one();
        check("opf_single_entry", clr_valid, 0);
        sof();
        hit_at(1, 0, 200, 300, 0, 0);
        check("opf_rearm_row", clr_row, 9);
        check("opf_rearm_col", clr_col, 6);
        pop_one();

        // Simultaneous, different cells (heading differs): rocket1 col 3, rocket2 col 2
        sof();
        hit_at(1, 1, 96, 70, 0, 1);
        check("sim_first_col", clr_col, 3);
        tick();
        check("sim_hold_col", clr_col, 3);
        pop_one();
        check("sim_second_valid", clr_valid, 1);
        check("sim_second_row", clr_row, 2);
        check("sim_second_col", clr_col, 2);
        pop_one();
        check("sim_empty", clr_valid, 0);

        // Simultaneous, same cell
        sof();
        hit_at(1, 1, 100, 70, 0, 0);
        pop_one();
        check("same_cell_single", clr_valid, 0);

        // Overflow: six events with no pops
        base1 = hits1;
        for (int k = 1; k <= 6; k++) begin
            sof();
            hit_at(1, 0, 32 * k, 32 * k, 0, 0);
            tick();
            if (k == 4) check("ovf_not_yet", overflow, 0);
        end
        check("ovf_set", overflow, 1);
        check("ovf_hits_still_fire", hits1 - base1, 6);
        check("ovf_head_row", clr_row, 1);
        for (int k = 1; k <= 4; k++) begin
            check("ovf_order_valid", clr_valid, 1);
            check("ovf_order_row", clr_row, k);
            check("ovf_order_col", clr_col, k);
            pop_one();
        end
        check("ovf_drained", clr_valid, 0);
        check("ovf_sticky", overflow, 1);

        // Reset mid-queue
        sof();
        hit_at(1, 0, 100, 70, 0, 0);
        sof();
        hit_at(1, 0, 200, 300, 0, 0);
        check("rmq_queued", clr_valid, 1);
        reset = 1'b1;
        #1;
        check("rmq_async_valid", clr_valid, 0);
        check("rmq_async_ovf", overflow, 0);
        tick();
        reset = 1'b0;
        tick();
        base1 = hits1;
        base2 = hits2;
        hit_at(1, 1, 100, 70, 0, 0);
        tick();
        check("rmq_no_hit", (hits1 - base1) + (hits2 - base2), 0);
        check("rmq_no_entry", clr_valid, 0);
        sof();
        hit_at(1, 0, 100, 70, 0, 0);
        check("rmq_rearmed_hit", rocket1_hit, 1);
        check("rmq_rearmed_col", clr_col, 3);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
